// File: rtl/snake_dir_input.sv
// snake_dir_input: sync + debounce four buttons, latch newest press until tick.
// Optional SNAKE_REVERSE_BLOCK_EN drops presses opposite to the last committed dir.
module snake_dir_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_btn_left,
  input  logic i_btn_right,
  input  logic i_tick,
  output logic o_up,
  output logic o_down,
  output logic o_left,
  output logic o_right,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // bit index is the direction code: up=0 down=1 left=2 right=3
  logic [3:0]       btn_raw;
  logic [3:0]       s1_q, s2_q;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             tick_d_q;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_dir_q, pend_dir_d;
  logic [3:0]       dir_q, dir_d;
  logic             press_q;
  logic [3:0]       evt;
  logic [1:0]       win;
  logic             blocked;
  logic             accept;
  logic             tick_edge;
`ifdef SNAKE_REVERSE_BLOCK_EN
  logic             cmt_vld_q, cmt_vld_d;
  logic [1:0]       cmt_dir_q, cmt_dir_d;
`endif

  assign btn_raw = {i_btn_right, i_btn_left, i_btn_down, i_btn_up};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign evt       = stable_q & ~prev_q;
  assign tick_edge = i_tick & ~tick_d_q;

  always_comb begin
    win = 2'd0;
    priority case (1'b1)
      evt[0]:  win = 2'd0;
      evt[1]:  win = 2'd1;
      evt[2]:  win = 2'd2;
      evt[3]:  win = 2'd3;
      default: win = 2'd0;
    endcase
  end

  // opposite directions differ only in bit 0 of the code
`ifdef SNAKE_REVERSE_BLOCK_EN
  assign blocked = cmt_vld_q && (win == (cmt_dir_q ^ 2'b01));
`else
  assign blocked = 1'b0;
`endif
  assign accept = (|evt) & ~blocked;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
`ifdef SNAKE_REVERSE_BLOCK_EN
    cmt_vld_d  = cmt_vld_q;
    cmt_dir_d  = cmt_dir_q;
`endif
    if (tick_edge && pend_vld_q) begin
`ifdef SNAKE_REVERSE_BLOCK_EN
      cmt_vld_d = 1'b1;
      cmt_dir_d = pend_dir_q;
`endif
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_dir_d = win;
    end
    dir_d = pend_vld_d ? (4'd1 << pend_dir_d) : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      tick_d_q   <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= 2'd0;
      dir_q      <= 4'd0;
      press_q    <= 1'b0;
    end else begin
      s1_q       <= btn_raw;
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      prev_q     <= stable_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      tick_d_q   <= i_tick;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      dir_q      <= dir_d;
      press_q    <= accept;
    end
  end

`ifdef SNAKE_REVERSE_BLOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmt_vld_q <= 1'b0;
      cmt_dir_q <= 2'd0;
    end else begin
      cmt_vld_q <= cmt_vld_d;
      cmt_dir_q <= cmt_dir_d;
    end
  end
`endif

  assign o_up    = dir_q[0];
  assign o_down  = dir_q[1];
  assign o_left  = dir_q[2];
  assign o_right = dir_q[3];
  assign o_press = press_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed vector bench for snake_dir_input with an 8-cycle debounce.
// Vectors are {buttons up,down,left,right; tick; cycles; expected dirs; presses}.
module tb_snake_dir_input;

  typedef struct {
    logic [3:0] btn;
    logic       tick;
    int         w;
    logic [3:0] dir;
    int         np;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_up = 1'b0, b_down = 1'b0, b_left = 1'b0, b_right = 1'b0;
  logic tick = 1'b0;
  logic o_up, o_down, o_left, o_right, o_press;

  int checks = 0;
  int failures = 0;
  int np;
  vec_t tv [35];

  always #5 clk = ~clk;

  snake_dir_input #(.DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .i_btn_up(b_up), .i_btn_down(b_down),
    .i_btn_left(b_left), .i_btn_right(b_right),
    .i_tick(tick),
    .o_up(o_up), .o_down(o_down), .o_left(o_left), .o_right(o_right),
    .o_press(o_press)
  );

  function automatic logic [3:0] dirs();
    return {o_up, o_down, o_left, o_right};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic t);
    {b_up, b_down, b_left, b_right} = b;
    tick = t;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (o_press) np++;
    end
  endtask

  initial begin
    tv[0]  = '{4'b0000, 1'b0,    5, 4'b0000, 0};
    tv[1]  = '{4'b0010, 1'b0,   10, 4'b0000, 0};
    tv[2]  = '{4'b0010, 1'b0,    1, 4'b0010, 1};
    tv[3]  = '{4'b0010, 1'b0,   20, 4'b0010, 0};
    tv[4]  = '{4'b0000, 1'b0,   12, 4'b0010, 0};
    tv[5]  = '{4'b0000, 1'b1,    1, 4'b0000, 0};
    tv[6]  = '{4'b0000, 1'b0,    2, 4'b0000, 0};
    tv[7]  = '{4'b0101, 1'b0,   10, 4'b0000, 0};
    tv[8]  = '{4'b0101, 1'b0,    1, 4'b0100, 1};
    tv[9]  = '{4'b0101, 1'b0,   20, 4'b0100, 0};
    tv[10] = '{4'b0000, 1'b0,   12, 4'b0100, 0};
    tv[11] = '{4'b0010, 1'b0,   11, 4'b0010, 1};
    tv[12] = '{4'b0000, 1'b0,   12, 4'b0010, 0};
    tv[13] = '{4'b1000, 1'b0,   11, 4'b1000, 1};
    tv[14] = '{4'b1000, 1'b0, 1000, 4'b1000, 0};
    tv[15] = '{4'b1000, 1'b1,    1, 4'b0000, 0};
    tv[16] = '{4'b1000, 1'b0,   30, 4'b0000, 0};
    tv[17] = '{4'b0000, 1'b0,   12, 4'b0000, 0};
    tv[18] = '{4'b0001, 1'b0,   11, 4'b0001, 1};
    tv[19] = '{4'b0000, 1'b0,   12, 4'b0001, 0};
    tv[20] = '{4'b1000, 1'b0,   10, 4'b0001, 0};
    tv[21] = '{4'b1000, 1'b1,    1, 4'b1000, 1};
    tv[22] = '{4'b1000, 1'b0,   12, 4'b1000, 0};
    tv[23] = '{4'b0000, 1'b0,   12, 4'b1000, 0};
    tv[24] = '{4'b0000, 1'b1,    1, 4'b0000, 0};
    tv[25] = '{4'b0000, 1'b0,    2, 4'b0000, 0};
    tv[26] = '{4'b0010, 1'b0,   11, 4'b0010, 1};
    tv[27] = '{4'b0000, 1'b0,   12, 4'b0010, 0};
    tv[28] = '{4'b0000, 1'b1,    1, 4'b0000, 0};
    tv[29] = '{4'b0000, 1'b0,    2, 4'b0000, 0};
`ifdef SNAKE_REVERSE_BLOCK_EN
    tv[30] = '{4'b0001, 1'b0,   11, 4'b0000, 0};
    tv[31] = '{4'b0000, 1'b0,   12, 4'b0000, 0};
`else
    tv[30] = '{4'b0001, 1'b0,   11, 4'b0001, 1};
    tv[31] = '{4'b0000, 1'b0,   12, 4'b0001, 0};
`endif
    tv[32] = '{4'b1000, 1'b0,   11, 4'b1000, 1};
    tv[33] = '{4'b0000, 1'b0,   12, 4'b1000, 0};
    tv[34] = '{4'b0100, 1'b0,   11, 4'b0100, 1};

    repeat (2) @(negedge clk);
    chk("reset_dirs", int'(dirs()), 0);
    chk("reset_press", int'(o_press), 0);
    rst = 1'b0;

    for (int i = 0; i < 35; i++) begin
      if (i == 4) begin
        // left is stable high: 3-cycle glitches must be rejected
        np = 0;
        for (int k = 0; k < 50; k++) begin
          drive({2'b00, ((k / 3) % 2) == 1, 1'b0}, 1'b0);
          run(1);
          chk($sformatf("glitch_dir_%0d", k), int'(dirs()), 4'b0010);
        end
        chk("glitch_press", np, 0);
      end
      drive(tv[i].btn, tv[i].tick);
      np = 0;
      run(tv[i].w);
      chk($sformatf("vec%0d_dir", i), int'(dirs()), int'(tv[i].dir));
      chk($sformatf("vec%0d_press", i), np, tv[i].np);
    end

    // down pending, left mid-debounce, then asynchronous reset
    drive(4'b0010, 1'b0);
    np = 0;
    run(5);
    chk("pre_rst_dir", int'(dirs()), 4'b0100);
    chk("pre_rst_press", np, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dir", int'(dirs()), 0);
    chk("async_rst_press", int'(o_press), 0);
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    run(10);
    chk("post_rst_early", int'(dirs()), 0);
    run(1);
    chk("post_rst_dir", int'(dirs()), 4'b0010);
    chk("post_rst_press", np, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
